fetch_unit: RTL and testbench

//  Instruction fetch stage. Owns the program counter and drives the word address into
//  the synchronous-read instruction memory. Captures the returned word one cycle later
//  and presents {pc, instr} to decode over a valid/ready handshake.

---
 rtl/fetch_unit.sv | 104 ++++++++++
 tb/tb_fetch_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction memory and
// presents {pc, instr} to decode through a valid/ready handshake backed by a 1-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  logic [31:0] pc_q,         pc_d;
  logic        resp_v_q,     resp_v_d;
  logic [31:0] resp_pc_q,    resp_pc_d;
  logic        skid_v_q,     skid_v_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;

  logic [31:0] redirect_tgt;
  logic        redirect_take;
  logic        issue;
  logic        stall_capture;
  logic        skid_drain;

  assign redirect_tgt  = {redirect_pc[31:2], 2'b00};
  assign redirect_take = !rst && redirect_valid;

  // A new request is only safe when its response has somewhere to land next cycle:
  // the skid must be empty and the current response must not be stuck at decode.
  assign issue         = !rst && !redirect_valid && !skid_v_q && !(resp_v_q && !if_ready);
  assign stall_capture = resp_v_q && !skid_v_q && !if_ready;
  assign skid_drain    = skid_v_q && if_ready;

  assign imem_addr = redirect_take ? redirect_tgt : pc_q;

  assign if_valid  = !rst && !redirect_valid && (skid_v_q || resp_v_q);
  assign if_pc     = skid_v_q ? skid_pc_q    : resp_pc_q;
  assign if_instr  = skid_v_q ? skid_instr_q : imem_rdata;

  // NOTE: every target gets a default before any branch so this block can never infer a latch.
  always_comb begin
    pc_d         = pc_q;
    resp_v_d     = resp_v_q;
    resp_pc_d    = resp_pc_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (redirect_valid) begin
      skid_v_d  = 1'b0;
      resp_v_d  = 1'b1;
      resp_pc_d = redirect_tgt;
      pc_d      = redirect_tgt + 32'd4;
    end else begin
      if (issue) begin
        resp_v_d  = 1'b1;
        resp_pc_d = pc_q;
        pc_d      = pc_q + 32'd4;
      end else begin
        resp_v_d  = 1'b0;
      end

      if (stall_capture) begin
        skid_v_d     = 1'b1;
        skid_pc_d    = resp_pc_q;
        skid_instr_d = imem_rdata;
      end else if (skid_drain) begin
        skid_v_d     = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      resp_v_q     <= 1'b0;
      resp_pc_q    <= 32'h0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
    end else begin
      pc_q         <= pc_d;
      resp_v_q     <= resp_v_d;
      resp_pc_q    <= resp_pc_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  a_addr_aligned : assert property (@(posedge clk) disable iff (rst)
    imem_addr[1:0] == 2'b00);

  a_out_stable : assert property (@(posedge clk) disable iff (rst)
    (if_valid && !if_ready) |=> (!if_valid || ($stable(if_pc) && $stable(if_instr))));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks of fetch_unit (reset, stall, redirect, flush, wrap) followed by a
// randomized ready/redirect run scored against an architectural PC model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int n_vec;
  int n_err;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory where word i holds the value i.
  always @(posedge clk) imem_rdata <= {2'b00, imem_addr[31:2]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge; return at the falling edge for sampling.
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    @(negedge clk);
  endtask

  task automatic see(input string tag, input logic v, input logic [31:0] pc);
    check({tag, ".valid"}, {31'h0, if_valid}, {31'h0, v});
    if (v) begin
      check({tag, ".pc"},    if_pc,    pc);
      check({tag, ".instr"}, if_instr, {2'b00, pc[31:2]});
    end
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        rv;
    logic        rdy;
    int          n_xfer;

    n_vec          = 0;
    n_err          = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    if_ready       = 1'b1;

    // Reset and streaming from RESET_PC
    cyc(1, 0, 0, 1); see("rst0", 0, 0);
    cyc(1, 0, 0, 1); see("rst1", 0, 0);
    cyc(0, 0, 0, 1); see("t1.issue", 0, 0); check("t1.addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 1); see("t1.c1", 1, 32'h100);
    cyc(0, 0, 0, 1); see("t1.c2", 1, 32'h104);

    // Stall 3 cycles on 0x108, one bubble after release
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0); see("t2.hold", 1, 32'h108);
    end
    cyc(0, 0, 0, 1); see("t2.drain", 1, 32'h108);
    cyc(0, 0, 0, 1); see("t2.bubble", 0, 0); check("t2.addr", imem_addr, 32'h10C);
    cyc(0, 0, 0, 1); see("t2.next", 1, 32'h10C);

    // Redirect while 0x110 would be presented
    cyc(0, 1, 32'h200, 1); see("t3.flush", 0, 0); check("t3.addr", imem_addr, 32'h200);
    cyc(0, 0, 0, 1); see("t3.tgt", 1, 32'h200);
    cyc(0, 0, 0, 1); see("t3.tgt4", 1, 32'h204);

    // Redirect with skid full and decode stalled
    cyc(0, 0, 0, 0); see("t4.stall", 1, 32'h208);
    cyc(0, 0, 0, 0); see("t4.skid", 1, 32'h208);
    cyc(0, 1, 32'h302, 0); see("t4.flush", 0, 0); check("t4.addr", imem_addr, 32'h300);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0); see("t4.hold", 1, 32'h300);
    end
    cyc(0, 0, 0, 1); see("t4.drain", 1, 32'h300);
    cyc(0, 0, 0, 1); see("t4.bubble", 0, 0);
    cyc(0, 0, 0, 1); see("t4.next", 1, 32'h304);

    // Reset mid-stall with skid full
    cyc(0, 0, 0, 0); see("t5.stall", 1, 32'h308);
    cyc(0, 0, 0, 0); see("t5.skid", 1, 32'h308);
    cyc(1, 0, 0, 0); see("t5.rst", 0, 0);
    cyc(0, 0, 0, 1); see("t5.issue", 0, 0); check("t5.addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 1); see("t5.c1", 1, 32'h100);
    cyc(0, 0, 0, 1); see("t5.c2", 1, 32'h104);

    // PC wrap at the top of the address space
    cyc(0, 1, 32'hFFFF_FFFE, 1); see("wrap.flush", 0, 0);
    check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1); see("wrap.top", 1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1); see("wrap.zero", 1, 32'h0);
    cyc(0, 0, 0, 1); see("wrap.four", 1, 32'h4);

    // Random ready/redirect against the architectural PC sequence
    exp_pc = 32'h8;
    n_xfer = 0;
    for (int i = 0; i < 4000; i++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rdy = 1'($urandom_range(0, 1));
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 | {27'h0, tgt[4:0]};
      cyc(0, rv, tgt, rdy);
      if (rv) begin
        check("rnd.flush", {31'h0, if_valid}, 32'h0);
        check("rnd.addr", imem_addr, {tgt[31:2], 2'b00});
        exp_pc = {tgt[31:2], 2'b00};
      end else if (if_valid && if_ready) begin
        check("rnd.pc", if_pc, exp_pc);
        check("rnd.instr", if_instr, {2'b00, exp_pc[31:2]});
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
    end
    check("rnd.progress", {31'h0, n_xfer > 500}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
